// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by both the read and write sides:
// output-buffer state encoding and pointer compare helpers.
package fifo_pkg;

  // Occupancy of the 2-entry read-side output buffer; encoding equals the word count.
  typedef enum logic [1:0] {
    OB_ZERO = 2'd0,
    OB_ONE  = 2'd1,
    OB_TWO  = 2'd2
  } obuf_state_e;

  // Pointers of any width are zero-extended into this word for the helpers below.
  localparam int unsigned PtrMaxW = 32;
  typedef logic [PtrMaxW-1:0] ptr_word_t;

  // Storage is empty when both pointers, including the wrap bit, match.
  function automatic logic ptr_empty(input ptr_word_t r_ptr, input ptr_word_t w_ptr);
    return r_ptr == w_ptr;
  endfunction

  // Storage is full when the address bits match but the wrap bits differ.
  // aw is the address width; bit aw of each pointer is its wrap bit.
  function automatic logic ptr_full(input ptr_word_t w_ptr, input ptr_word_t r_ptr,
                                    input int unsigned aw);
    ptr_word_t mask;
    mask = (ptr_word_t'(1) << aw) - ptr_word_t'(1);
    return ((w_ptr & mask) == (r_ptr & mask)) && (w_ptr[aw] != r_ptr[aw]);
  endfunction

endpackage

// File: rtl/fifo_obuf.sv
// Two-entry output buffer (head + skid) feeding a valid/ready stream.
// The caller must not assert load_i while the buffer holds two words.
module fifo_obuf
  import fifo_pkg::*;
#(
  parameter int DWidth = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DWidth-1:0] data_i,
  input  logic              ready_i,
  output obuf_state_e       cnt_o,
  output logic              valid_o,
  output logic [DWidth-1:0] data_o
);

  obuf_state_e       state_q, state_d;
  logic [DWidth-1:0] head_q, head_d;
  logic [DWidth-1:0] skid_q, skid_d;
  logic              pop;

  assign pop = (state_q != OB_ZERO) && ready_i;

  // State and data registers; reset discards any buffered words.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OB_ZERO;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  // Next-state: head always leaves first, skid refills head, new words fill the free slot.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      OB_ZERO: begin
        if (load_i) begin
          state_d = OB_ONE;
          head_d  = data_i;
        end
      end
      OB_ONE: begin
        if (load_i && pop) begin
          head_d = data_i;
        end else if (load_i) begin
          state_d = OB_TWO;
          skid_d  = data_i;
        end else if (pop) begin
          state_d = OB_ZERO;
        end
      end
      OB_TWO: begin
        if (pop) begin
          state_d = OB_ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = OB_ZERO;
    endcase
  end

  assign cnt_o   = state_q;
  assign valid_o = (state_q != OB_ZERO);
  assign data_o  = head_q;

endmodule

// File: rtl/fifo_rd_port.sv
// Read-side controller for fifomem: owns the read pointer, detects empty and
// streams words out through a 2-entry output buffer.
// Optional FIFO_RD_LEVEL_EN adds a registered occupancy output level_o.
module fifo_rd_port
  import fifo_pkg::*;
#(
  parameter  int DWidth = 8,
  parameter  int Depth  = 8,
  localparam int AWidth = $clog2(Depth),
  localparam int LWidth = $clog2(Depth + 3)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [AWidth:0]   w_ptr_i,
  output logic [AWidth-1:0] r_addr_o,
  input  logic [DWidth-1:0] r_data_i,
  output logic [AWidth:0]   r_ptr_o,
  output logic              empty_o,
  output logic [DWidth-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [LWidth-1:0] level_o
`endif
);

  typedef logic [AWidth:0] ptr_t;

  localparam ptr_t DepthPtr = ptr_t'(Depth);

  ptr_t        r_ptr_q, r_ptr_d;
  ptr_t        fill;
  logic        empty;
  logic        fetch;
  obuf_state_e cnt;

  // Fetch depends only on storage and buffer occupancy, never on m_ready_i,
  // so the consumer has no combinational path into the memory address.
  assign empty   = ptr_empty(ptr_word_t'(r_ptr_q), ptr_word_t'(w_ptr_i));
  assign fetch   = !empty && (cnt != OB_TWO);
  assign r_ptr_d = r_ptr_q + ptr_t'(fetch);
  assign fill    = w_ptr_i - r_ptr_q;

  // Read pointer advances by one on every fetch, wrapping through the MSB.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr_q <= '0;
    end else begin
      r_ptr_q <= r_ptr_d;
    end
  end

  fifo_obuf #(
    .DWidth(DWidth)
  ) u_obuf (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (fetch),
    .data_i (r_data_i),
    .ready_i(m_ready_i),
    .cnt_o  (cnt),
    .valid_o(m_valid_o),
    .data_o (m_data_o)
  );

  assign r_addr_o = r_ptr_q[AWidth-1:0];
  assign r_ptr_o  = r_ptr_q;
  assign empty_o  = empty;

`ifdef FIFO_RD_LEVEL_EN
  logic [LWidth-1:0] level_q, level_d;

  assign level_d = LWidth'(fill) + LWidth'(cnt);

  // Total words held (storage plus output buffer), registered every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level_o = level_q;
`endif

  // The writer must never get more than Depth words ahead of the reader.
  a_no_overfill : assert property (@(posedge clk_i) disable iff (rst_i) fill <= DepthPtr);

endmodule

// File: tb/tb_fifo_rd_port.sv
// Bench for fifo_rd_port with a behavioural writer and fifomem model.
module tb_fifo_rd_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       m_ready = 1'b0;

  logic [2:0] r_addr;
  logic [7:0] r_data;
  logic [3:0] r_ptr;
  logic       empty;
  logic [7:0] m_data;
  logic       m_valid;
`ifdef FIFO_RD_LEVEL_EN
  logic [3:0] level;
`endif

  logic [3:0] wptr;
  logic [7:0] mem [8];
  logic       full;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int n_wr = 0;
  int n_pop = 0;
  int last_infifo = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_t[$];

  always #5 clk = ~clk;

  fifo_rd_port #(.DWidth(8), .Depth(8)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .w_ptr_i  (wptr),
    .r_addr_o (r_addr),
    .r_data_i (r_data),
    .r_ptr_o  (r_ptr),
    .empty_o  (empty),
    .m_data_o (m_data),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .level_o  (level)
`endif
  );

  // Writer + storage model: accepts a word whenever not full.
  assign full   = (wptr[2:0] == r_ptr[2:0]) && (wptr[3] != r_ptr[3]);
  assign r_data = mem[r_addr];

  always @(posedge clk) begin
    if (rst) begin
      wptr <= 4'd0;
    end else if (wr_en && !full) begin
      mem[wptr[2:0]] <= wr_data;
      wptr <= wptr + 4'd1;
    end
  end

  // One clock: records accepted writes and consumed words, samples #1 after the edge.
  task automatic step();
    logic       rs, wacc, pacc;
    logic [7:0] wd, pd;
    int         inf;
    rs   = rst;
    wacc = !rst && wr_en && !full;
    wd   = wr_data;
    pacc = !rst && m_valid && m_ready;
    pd   = m_data;
    inf  = n_wr - n_pop;
    @(posedge clk);
    #1;
    cyc++;
    if (rs) begin
      n_wr = 0;
      n_pop = 0;
      exp_q.delete();
      got_q.delete();
      got_t.delete();
      last_infifo = 0;
    end else begin
      if (wacc) begin
        exp_q.push_back(wd);
        n_wr++;
      end
      if (pacc) begin
        got_q.push_back(pd);
        got_t.push_back(cyc);
        n_pop++;
      end
      last_infifo = inf;
    end
  endtask

  task automatic clear_hist();
    exp_q.delete();
    got_q.delete();
    got_t.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; m_ready = 1'b0;
    step(); step();
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    nvec++; if (r_ptr !== 4'd0) begin nerr++; $display("FAIL reset_rptr got=%h exp=0", r_ptr); end
    nvec++; if (m_data !== 8'h00) begin nerr++; $display("FAIL reset_data got=%h exp=00", m_data); end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      nvec++;
      if (r_ptr !== 4'd0 || m_valid !== 1'b0 || empty !== 1'b1) begin
        nerr++;
        $display("FAIL reset_hold cyc%0d rptr=%h valid=%b empty=%b exp rptr=0 valid=0 empty=1", i, r_ptr, m_valid, empty);
      end
    end
`ifdef FIFO_RD_LEVEL_EN
    nvec++; if (level !== 4'd0) begin nerr++; $display("FAIL reset_level got=%0d exp=0", level); end
`endif
    $display("test_reset done");
  endtask

  task automatic test_latency();
    clear_hist();
    m_ready = 1'b0; wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    nvec++; if (m_valid !== 1'b0) begin nerr++; $display("FAIL lat_t1_valid got=%b exp=0", m_valid); end
    nvec++; if (empty !== 1'b0) begin nerr++; $display("FAIL lat_t1_empty got=%b exp=0", empty); end
    step();
    nvec++; if (m_valid !== 1'b1) begin nerr++; $display("FAIL lat_t2_valid got=%b exp=1", m_valid); end
    nvec++; if (m_data !== 8'hA5) begin nerr++; $display("FAIL lat_t2_data got=%h exp=a5", m_data); end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    nvec++; if (m_valid !== 1'b0 || empty !== 1'b1) begin nerr++; $display("FAIL lat_t3 valid=%b empty=%b exp valid=0 empty=1", m_valid, empty); end
    nvec++; if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin nerr++; $display("FAIL lat_pop count=%0d exp count=1 word=a5", got_q.size()); end
    $display("test_latency done");
  endtask

  task automatic test_throughput();
    clear_hist();
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) step();
    nvec++; if (got_q.size() != 16) begin nerr++; $display("FAIL thr_count got=%0d exp=16", got_q.size()); end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] g;
      int         t;
      logic [7:0] e;
      e = 8'(i);
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      t = (i < got_t.size()) ? got_t[i] : -1;
      nvec++;
      if (g !== e || (i > 0 && t != got_t[0] + i)) begin
        nerr++;
        $display("FAIL thr_word%0d got=%h at cyc %0d exp=%h at cyc %0d", i, g, t, e, got_t[0] + i);
      end
    end
    nvec++; if (r_ptr !== 4'(n_pop) || empty !== 1'b1) begin nerr++; $display("FAIL thr_rptr got=%h empty=%b exp=%h empty=1", r_ptr, empty, 4'(n_pop)); end
    $display("test_throughput done");
  endtask

  task automatic test_backpressure();
    int base;
    clear_hist();
    base = n_pop;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    nvec++; if (exp_q.size() != 8) begin nerr++; $display("FAIL bp_accepted got=%0d exp=8", exp_q.size()); end
    nvec++; if (r_ptr !== 4'(base + 2)) begin nerr++; $display("FAIL bp_rptr got=%h exp=%h", r_ptr, 4'(base + 2)); end
    nvec++; if (m_valid !== 1'b1 || m_data !== exp_q[0]) begin nerr++; $display("FAIL bp_head valid=%b data=%h exp valid=1 data=%h", m_valid, m_data, exp_q[0]); end
`ifdef FIFO_RD_LEVEL_EN
    nvec++; if (level !== 4'd8) begin nerr++; $display("FAIL bp_level got=%0d exp=8", level); end
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      nvec++;
      if (m_valid !== 1'b1 || m_data !== exp_q[0] || r_ptr !== 4'(base + 2)) begin
        nerr++;
        $display("FAIL bp_hold%0d valid=%b data=%h rptr=%h exp valid=1 data=%h rptr=%h", i, m_valid, m_data, r_ptr, exp_q[0], 4'(base + 2));
      end
    end
    m_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    m_ready = 1'b0;
    nvec++; if (got_q.size() != 8) begin nerr++; $display("FAIL bp_count got=%0d exp=8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] g;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      nvec++;
      if (g !== exp_q[i]) begin nerr++; $display("FAIL bp_word%0d got=%h exp=%h", i, g, exp_q[i]); end
    end
    $display("test_backpressure done");
  endtask

  task automatic test_random();
    int guard;
    clear_hist();
    guard = 0;
    while (exp_q.size() < 1000 && guard < 6000) begin
      logic       pv, pr;
      logic [7:0] pd;
      wr_en   = ($urandom_range(0, 99) < 60);
      wr_data = 8'($urandom);
      m_ready = $urandom_range(0, 1) == 1;
      pv = m_valid; pr = m_ready; pd = m_data;
      step();
      guard++;
      if (pv && !pr) begin
        nvec++;
        if (m_valid !== 1'b1 || m_data !== pd) begin
          nerr++;
          $display("FAIL rnd_stable cyc%0d valid=%b data=%h exp valid=1 data=%h", cyc, m_valid, m_data, pd);
        end
      end
      if (n_wr - n_pop > 2) begin
        nvec++;
        if (empty !== 1'b0) begin nerr++; $display("FAIL rnd_empty cyc%0d got=%b exp=0 words=%0d", cyc, empty, n_wr - n_pop); end
      end
`ifdef FIFO_RD_LEVEL_EN
      nvec++;
      if (level !== 4'(last_infifo)) begin nerr++; $display("FAIL rnd_level cyc%0d got=%0d exp=%0d", cyc, level, last_infifo); end
`endif
    end
    wr_en = 1'b0; m_ready = 1'b1;
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 40) begin
      step();
      guard++;
    end
    m_ready = 1'b0;
    nvec++; if (got_q.size() != exp_q.size() || exp_q.size() != 1000) begin nerr++; $display("FAIL rnd_count got=%0d exp=%0d of 1000", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [7:0] g;
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      nvec++;
      if (g !== exp_q[i]) begin nerr++; $display("FAIL rnd_word%0d got=%h exp=%h", i, g, exp_q[i]); end
    end
    $display("test_random done: %0d words", got_q.size());
  endtask

  task automatic test_reset_midstream();
    clear_hist();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'($urandom);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    nvec++; if (r_ptr !== 4'(n_pop + 2) || m_valid !== 1'b1) begin nerr++; $display("FAIL mid_prefill rptr=%h valid=%b exp rptr=%h valid=1", r_ptr, m_valid, 4'(n_pop + 2)); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    nvec++; if (m_valid !== 1'b0 || r_ptr !== 4'd0 || empty !== 1'b1) begin nerr++; $display("FAIL mid_reset valid=%b rptr=%h empty=%b exp valid=0 rptr=0 empty=1", m_valid, r_ptr, empty); end
    wr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_en = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    m_ready = 1'b0;
    nvec++; if (got_q.size() != 1 || got_q[0] !== 8'h3C) begin nerr++; $display("FAIL mid_post count=%0d exp count=1 word=3c", got_q.size()); end
    nvec++; if (m_valid !== 1'b0 || empty !== 1'b1) begin nerr++; $display("FAIL mid_idle valid=%b empty=%b exp valid=0 empty=1", m_valid, empty); end
    $display("test_reset_midstream done");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_throughput();
    test_backpressure();
    test_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
